// File: rtl/ats21_pkg.sv
// Shared types and command field layout for the ats21 command front end.
package ats21_pkg;

  localparam int unsigned CMD_W = 32;

  // Command field positions
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 29;
  localparam int unsigned IDX_MSB = 28;
  localparam int unsigned IDX_LSB = 24;
  localparam int unsigned CFG_MSB = 23;
  localparam int unsigned CFG_LSB = 16;
  localparam int unsigned VAL_MSB = 15;
  localparam int unsigned VAL_LSB = 0;

  typedef enum logic [2:0] {
    NOP       = 3'b000,
    SET_CLK   = 3'b001,
    CLK_EN    = 3'b010,
    SET_MODE  = 3'b011,
    SET_ALARM = 3'b101,
    SET_TIMER = 3'b110,
    AT_EN     = 3'b111
  } opcode_t;

  // The one encoding the core does not define
  localparam logic [2:0] OPC_UNDEF = 3'b100;

  typedef enum logic {
    ASM_UPPER = 1'b0,
    ASM_LOWER = 1'b1
  } asm_state_t;

  function automatic logic [2:0] cmd_opcode(input logic [CMD_W-1:0] cmd);
    return cmd[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/ats21_cmd_fifo.sv
// Per-port command FIFO with registered occupancy count.
module ats21_cmd_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage array: written on accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ats21_cmd_arbiter.sv
// Two-port beat assembler, opcode screen, per-port queueing and round-robin
// command arbitration into the ats21 core.
module ats21_cmd_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CMD_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [15:0]      ctrl_a,
  output logic             rdy_a,
  output logic [1:0]       stat_a,
  input  logic             req_b,
  input  logic [15:0]      ctrl_b,
  output logic             rdy_b,
  output logic [1:0]       stat_b,
  output logic             cmd_valid,
  output logic [CMD_W-1:0] cmd_data,
  output logic             cmd_src,
  input  logic             cmd_ready
);

  import ats21_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [1:0]       req;
  logic [1:0]       rdy;
  logic [1:0]       beat;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       full;
  logic [1:0]       empty;
  logic [15:0]      ctrl    [2];
  logic [1:0]       stat    [2];
  logic [CMD_W-1:0] asm_cmd [2];
  logic [CMD_W-1:0] head    [2];
  logic [CNT_W-1:0] count   [2];

  logic ptr;
  logic any;
  logic win;
  logic load;

  assign req     = {req_b, req_a};
  assign ctrl[0] = ctrl_a;
  assign ctrl[1] = ctrl_b;
  assign rdy_a   = rdy[0];
  assign rdy_b   = rdy[1];
  assign stat_a  = stat[0];
  assign stat_b  = stat[1];

  for (genvar i = 0; i < 2; i++) begin : gen_port
    asm_state_t state;
    asm_state_t state_nxt;
    logic [15:0] hold;
    logic [1:0]  stat_q;
    logic [1:0]  stat_nxt;
    logic        push_req;
    logic [2:0]  opc;

    // Space check uses the registered count, so a same-cycle pop never
    // makes room for a beat.
    assign rdy[i]     = (count[i] < CNT_W'(DEPTH));
    assign beat[i]    = req[i] & rdy[i];
    assign asm_cmd[i] = {hold, ctrl[i]};
    assign opc        = cmd_opcode(asm_cmd[i]);
    assign push[i]    = push_req & ~full[i];
    assign stat[i]    = stat_q;

    // Assembler state, upper-half holding register and status pulse
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state  <= ASM_UPPER;
        hold   <= '0;
        stat_q <= '0;
      end else begin
        state  <= state_nxt;
        stat_q <= stat_nxt;
        if (beat[i] && state == ASM_UPPER) hold <= ctrl[i];
      end
    end

    // Beat sequencing and screening of the completed command
    always_comb begin
      state_nxt = state;
      push_req  = 1'b0;
      stat_nxt  = '0;
      case (state)
        ASM_UPPER: if (beat[i]) state_nxt = ASM_LOWER;
        ASM_LOWER: begin
          if (beat[i]) begin
            state_nxt = ASM_UPPER;
            if (opc == OPC_UNDEF) begin
              stat_nxt = 2'b10;
            end else begin
              stat_nxt = 2'b01;
              push_req = (opc != NOP);
            end
          end
        end
        default: state_nxt = ASM_UPPER;
      endcase
    end

    ats21_cmd_fifo #(
      .WIDTH(CMD_W),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (reset),
      .push     (push[i]),
      .push_data(asm_cmd[i]),
      .pop      (pop[i]),
      .pop_data (head[i]),
      .full     (full[i]),
      .empty    (empty[i]),
      .count    (count[i])
    );
  end

  // Winner selection: pointer breaks ties, otherwise the lone non-empty port
  always_comb begin
    any  = ~(empty[0] & empty[1]);
    load = ~cmd_valid | cmd_ready;
    if (!empty[0] && !empty[1]) win = ptr;
    else                        win = empty[0];
    pop = '0;
    if (load && any) pop[win] = 1'b1;
  end

  // Output register: reloads when idle or on a completed transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_data  <= '0;
      cmd_src   <= 1'b0;
      ptr       <= 1'b0;
    end else if (load) begin
      if (any) begin
        cmd_valid <= 1'b1;
        cmd_data  <= head[win];
        cmd_src   <= win;
        ptr       <= ~win;
      end else begin
        cmd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ats21_cmd_arbiter.sv
// Directed bench for ats21_cmd_arbiter.
module tb_ats21_cmd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b, cmd_ready;
  logic [15:0] ctrl_a, ctrl_b;
  logic        rdy_a, rdy_b, cmd_valid, cmd_src;
  logic [1:0]  stat_a, stat_b;
  logic [31:0] cmd_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ats21_cmd_arbiter #(.DEPTH(4), .CMD_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_a(req_a), .ctrl_a(ctrl_a), .rdy_a(rdy_a), .stat_a(stat_a),
    .req_b(req_b), .ctrl_b(ctrl_b), .rdy_b(rdy_b), .stat_b(stat_b),
    .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_src(cmd_src),
    .cmd_ready(cmd_ready)
  );

  task automatic beats(input logic ra, input logic [15:0] da,
                       input logic rb, input logic [15:0] db);
    @(negedge clk);
    req_a = ra; ctrl_a = da; req_b = rb; ctrl_b = db;
    @(posedge clk); #1;
    req_a = 1'b0; req_b = 1'b0;
  endtask

  task automatic send_a(input logic [31:0] c);
    beats(1'b1, c[31:16], 1'b0, 16'h0);
    beats(1'b1, c[15:0], 1'b0, 16'h0);
  endtask

  task automatic send_b(input logic [31:0] c);
    beats(1'b0, 16'h0, 1'b1, c[31:16]);
    beats(1'b0, 16'h0, 1'b1, c[15:0]);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0; ctrl_a = '0; ctrl_b = '0; cmd_ready = 1'b1;
    tick(); tick();
    checks++; if (rdy_a !== 1'b1) begin errors++; $display("FAIL reset_rdy_a got=%b exp=1", rdy_a); end
    checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL reset_rdy_b got=%b exp=1", rdy_b); end
    checks++; if (stat_a !== 2'b00 || stat_b !== 2'b00) begin errors++; $display("FAIL reset_stat got=%b/%b exp=00/00", stat_a, stat_b); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", cmd_valid); end
    checks++; if (cmd_data !== 32'h0 || cmd_src !== 1'b0) begin errors++; $display("FAIL reset_data got=%h/%b exp=0/0", cmd_data, cmd_src); end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic;
    cmd_ready = 1'b1;
    send_a(32'h2A000010);
    checks++; if (stat_a !== 2'b01) begin errors++; $display("FAIL basic_stat got=%b exp=01", stat_a); end
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", cmd_valid); end
    tick();
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", cmd_valid); end
    checks++; if (cmd_data !== 32'h2A000010) begin errors++; $display("FAIL basic_data got=%h exp=2a000010", cmd_data); end
    checks++; if (cmd_src !== 1'b0) begin errors++; $display("FAIL basic_src got=%b exp=0", cmd_src); end
    checks++; if (stat_a !== 2'b00) begin errors++; $display("FAIL basic_stat_pulse got=%b exp=00", stat_a); end
    tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0", cmd_valid); end
  endtask

  task automatic test_screen;
    beats(1'b1, 16'h8000, 1'b1, 16'h0000);
    beats(1'b1, 16'h1234, 1'b1, 16'h0000);
    checks++; if (stat_a !== 2'b10) begin errors++; $display("FAIL screen_undef got=%b exp=10", stat_a); end
    checks++; if (stat_b !== 2'b01) begin errors++; $display("FAIL screen_nop got=%b exp=01", stat_b); end
    tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL screen_valid got=%b exp=0", cmd_valid); end
    checks++; if (stat_a !== 2'b00 || stat_b !== 2'b00) begin errors++; $display("FAIL screen_pulse got=%b/%b exp=00/00", stat_a, stat_b); end
  endtask

  task automatic test_round_robin;
    logic [31:0] exp_d [3];
    logic        exp_s [3];
    exp_d[0] = 32'h63000003; exp_s[0] = 1'b1;
    exp_d[1] = 32'h42000002; exp_s[1] = 1'b0;
    exp_d[2] = 32'hA4000004; exp_s[2] = 1'b1;
    cmd_ready = 1'b0;
    send_a(32'h21000001);
    send_a(32'h42000002);
    send_b(32'h63000003);
    send_b(32'hA4000004);
    tick();
    checks++; if (cmd_valid !== 1'b1 || cmd_data !== 32'h21000001 || cmd_src !== 1'b0)
      begin errors++; $display("FAIL rr_first got=%b/%h/%b exp=1/21000001/0", cmd_valid, cmd_data, cmd_src); end
    @(negedge clk); cmd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (cmd_valid !== 1'b1 || cmd_data !== exp_d[k] || cmd_src !== exp_s[k])
        begin errors++; $display("FAIL rr_order%0d got=%b/%h/%b exp=1/%h/%b", k, cmd_valid, cmd_data, cmd_src, exp_d[k], exp_s[k]); end
    end
    tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rr_empty got=%b exp=0", cmd_valid); end
  endtask

  task automatic test_full;
    logic [31:0] fc [5];
    logic [31:0] exp_d [4];
    for (int k = 0; k < 5; k++) fc[k] = {16'hE000 | 16'(k), 16'(k)};
    cmd_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_a(fc[k]);
    checks++; if (rdy_a !== 1'b0) begin errors++; $display("FAIL full_rdy_a got=%b exp=0", rdy_a); end
    checks++; if (rdy_b !== 1'b1) begin errors++; $display("FAIL full_rdy_b got=%b exp=1", rdy_b); end
    checks++; if (cmd_valid !== 1'b1 || cmd_data !== fc[0]) begin errors++; $display("FAIL full_head got=%b/%h exp=1/%h", cmd_valid, cmd_data, fc[0]); end
    @(negedge clk); req_a = 1'b1; ctrl_a = 16'h2B00;
    tick(); tick();
    checks++; if (rdy_a !== 1'b0 || cmd_data !== fc[0]) begin errors++; $display("FAIL full_stall got=%b/%h exp=0/%h", rdy_a, cmd_data, fc[0]); end
    req_a = 1'b0;
    @(negedge clk); cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checks++; if (rdy_a !== 1'b1 || cmd_data !== fc[1]) begin errors++; $display("FAIL full_release got=%b/%h exp=1/%h", rdy_a, cmd_data, fc[1]); end
    send_a(32'h2B000006);
    checks++; if (stat_a !== 2'b01 || rdy_a !== 1'b0) begin errors++; $display("FAIL full_refill got=%b/%b exp=01/0", stat_a, rdy_a); end
    exp_d[0] = fc[2]; exp_d[1] = fc[3]; exp_d[2] = fc[4]; exp_d[3] = 32'h2B000006;
    @(negedge clk); cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (cmd_valid !== 1'b1 || cmd_data !== exp_d[k] || cmd_src !== 1'b0)
        begin errors++; $display("FAIL full_drain%0d got=%b/%h/%b exp=1/%h/0", k, cmd_valid, cmd_data, cmd_src, exp_d[k]); end
    end
    tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL full_empty got=%b exp=0", cmd_valid); end
  endtask

  task automatic test_hold;
    cmd_ready = 1'b0;
    send_b(32'hC5000055);
    checks++; if (stat_b !== 2'b01) begin errors++; $display("FAIL hold_stat got=%b exp=01", stat_b); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (cmd_valid !== 1'b1 || cmd_data !== 32'hC5000055 || cmd_src !== 1'b1)
        begin errors++; $display("FAIL hold_cycle%0d got=%b/%h/%b exp=1/c5000055/1", k, cmd_valid, cmd_data, cmd_src); end
    end
    @(negedge clk); cmd_ready = 1'b1;
    tick();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL hold_xfer got=%b exp=0", cmd_valid); end
  endtask

  task automatic test_reset_mid;
    cmd_ready = 1'b0;
    send_a(32'h20000001);
    tick();
    checks++; if (cmd_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%b exp=1", cmd_valid); end
    beats(1'b1, 16'hA100, 1'b0, 16'h0);
    @(negedge clk); reset = 1'b1;
    #1;
    checks++; if (cmd_valid !== 1'b0 || cmd_data !== 32'h0) begin errors++; $display("FAIL rst_async got=%b/%h exp=0/0", cmd_valid, cmd_data); end
    @(negedge clk); reset = 1'b0;
    beats(1'b1, 16'h0005, 1'b0, 16'h0);
    checks++; if (stat_a !== 2'b00) begin errors++; $display("FAIL rst_upper got=%b exp=00", stat_a); end
    beats(1'b1, 16'h0007, 1'b0, 16'h0);
    checks++; if (stat_a !== 2'b01) begin errors++; $display("FAIL rst_nop_stat got=%b exp=01", stat_a); end
    tick();
    checks++; if (cmd_valid !== 1'b0 || stat_a !== 2'b00) begin errors++; $display("FAIL rst_nop_drop got=%b/%b exp=0/00", cmd_valid, stat_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_screen();
    test_round_robin();
    test_full();
    test_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/ats21_cmd_arbiter.md
Name: ats21_cmd_arbiter

Overview:
Front-end controller for the ats21 alarm/timer core. It assembles 32-bit commands from two 16-bit requester ports (A and B), each sent as two beats with the upper half first. It screens opcodes, buffers commands per port, and round-robin arbitrates a single valid/ready command stream into the core. It replaces the core's ad-hoc per-port latching with one serialized, back-pressured command path.

Parameters:
DEPTH, 4, entries per per-port command FIFO (power of 2, >=2)
CMD_W, 32, assembled command width (fixed; parameter for package consistency)

Ports:
clk  input  1  single system clock
reset  input  1  asynchronous, active-high reset
req_a  input  1  port A beat valid
ctrl_a  input  16  port A beat data
rdy_a  output  1  port A can accept a beat
stat_a  output  2  port A status pulse: [0]=command accepted, [1]=command rejected
req_b  input  1  port B beat valid
ctrl_b  input  16  port B beat data
rdy_b  output  1  port B can accept a beat
stat_b  output  2  port B status pulse, same encoding as stat_a
cmd_valid  output  1  command available to core
cmd_data  output  32  command to core
cmd_src  output  1  origin of cmd_data: 0=A, 1=B
cmd_ready  input  1  core accepts cmd_data this cycle

Behaviour:
- Reset (async assert, sync release): rdy_a=rdy_b=1, stat_a=stat_b=0, cmd_valid=0, cmd_data=0, cmd_src=0, both FIFOs empty, both assemblers in UPPER, priority pointer=A.
- A beat is taken on a clock edge with req_x && rdy_x.
- rdy_x = (FIFO_x count < DEPTH), computed from registered count. A pop in the same cycle does not free space for a push.
- Assembler FSM per port:
  - UPPER: on beat, latch ctrl_x into hold[31:16], go to LOWER.
  - LOWER: on beat, form {hold, ctrl_x}, screen it, go to UPPER. With no beat, stay in LOWER indefinitely (no timeout).
- Screening happens at the LOWER beat edge. opcode = cmd[31:29].
  - 3'b100 (undefined): discarded; stat_x[1] pulses one cycle.
  - 3'b000 (nop): discarded; stat_x[0] pulses.
  - All other opcodes: written to FIFO_x; stat_x[0] pulses.
  - stat pulses are registered and high for exactly the cycle after the LOWER beat.
- Arbiter / output register:
  - When cmd_valid=0, or on a cmd_valid&&cmd_ready transfer, the output register loads the next head.
  - If both FIFOs are non-empty, the port named by the priority pointer wins. Otherwise the single non-empty FIFO wins.
  - On load: pop the winner, set cmd_src, set cmd_valid=1, and flip the pointer to the other port. With nothing pending, cmd_valid=0.
  - While cmd_valid && !cmd_ready, cmd_data and cmd_src are held stable.
- Latency: LOWER beat at edge N, both FIFOs empty, output idle → cmd_valid=1 after edge N+1. Back-to-back transfers sustain 1 command/cycle.
- Simultaneous events:
  - Both ports completing a command on the same edge: both are written.
  - Each FIFO receives its commands in order; relative A/B order follows round-robin only.
- Full FIFO: rdy_x=0 blocks both UPPER and LOWER beats. A partial command in hold is kept until space frees.
- Reset mid-assembly or mid-handshake: partial commands and queued commands are lost. cmd_valid drops immediately on reset assertion.

Decomposition:
- Package ats21_pkg:
  - opcode_t enum: NOP=000, SET_CLK=001, CLK_EN=010, SET_MODE=011, SET_ALARM=101, SET_TIMER=110, AT_EN=111
  - CMD_W
  - field constants: OPC_MSB=31, OPC_LSB=29, IDX=28:24, CFG=23:16, VAL=15:0
- Sub-module ats21_cmd_fifo (CMD_W wide, DEPTH deep, push/pop/full/empty/count), instanced once per port. The assembler and arbiter live in the top.

Test Plan:
- Reset, then A beats 0x2A00,0x0010 (SET_CLK) with cmd_ready=1 → stat_a=01 for one cycle; one cycle later cmd_valid=1, cmd_data=0x2A000010, cmd_src=0.
- A sends 0x8000,0x1234 (opcode 100) and B sends 0x0000,0x0000 (nop) → stat_a=10, stat_b=01; cmd_valid stays 0.
- A and B each queue 2 commands (A1,A2,B1,B2) with cmd_ready=0, then cmd_ready=1 → output order A1,B1,A2,B2 with cmd_src=0,1,0,1.
- cmd_ready=0 with 5 A commands sent → 4 queued plus 1 in output register after first load; rdy_a=0 stalls the 6th upper beat; raising cmd_ready for one cycle → rdy_a=1 the next cycle.
- cmd_valid held 3 cycles with cmd_ready=0 → cmd_data and cmd_src unchanged throughout; transfer completes on the first cmd_ready=1 edge.
- Assert reset after an A upper beat 0xA100, then send 0x0005,0x0007 → the first beat is treated as UPPER; assembled cmd = 0x00050007 (nop) is dropped with stat_a=01.
